// File: rtl/key_event_queue.sv
// PS/2 key event queue: toggle-detected events into a FIFO with repeat
// filtering, paced valid/ready output and a legacy toggling strobe.
module key_event_queue #(
   parameter int DEPTH         = 8,
   parameter bit FILTER_REPEAT = 1'b1,
   parameter int PACE_CYCLES   = 0
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic [10:0]              ps2_key,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [8:0]               evt_code,
   output logic                     evt_pressed,
   output logic                     key_strobe,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] PACE = 16'(PACE_CYCLES);

   typedef logic [AW:0] ptr_t;

   logic        tgl_q;
   ptr_t        wptr_q, wptr_d;
   ptr_t        rptr_q, rptr_d;
   logic [9:0]  mem_q [DEPTH];
   logic [8:0]  last_code_q, last_code_d;
   logic        last_pr_q, last_pr_d;
   logic [15:0] pace_q, pace_d;
   logic        valid_q, valid_d;
   logic [8:0]  code_q, code_d;
   logic        pr_q, pr_d;
   logic        strobe_q, strobe_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  drops_q, drops_d;

   logic       evt, rep, full, pop, push, drop;
   logic [9:0] cand, head;

   assign evt  = ps2_key[10] ^ tgl_q;
   assign cand = {ps2_key[8:0], ps2_key[9]};
   assign rep  = FILTER_REPEAT && ps2_key[9] && last_pr_q &&
                 (ps2_key[8:0] == last_code_q);
   assign full = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                 (wptr_q[AW] != rptr_q[AW]);
   assign pop  = valid_q && evt_ready;
   assign push = evt && !rep && (!full || pop);
   assign drop = evt && !rep && full && !pop;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      last_code_d = last_code_q;
      last_pr_d   = last_pr_q;
      pace_d      = pace_q;
      strobe_d    = strobe_q;
      ovf_d       = ovf_q;
      drops_d     = drops_q;
      code_d      = code_q;
      pr_d        = pr_q;
      head        = '0;
      if (pop) begin
         rptr_d   = rptr_q + ptr_t'(1);
         strobe_d = ~strobe_q;
         pace_d   = PACE;
      end else if (pace_q != 16'd0) begin
         pace_d = pace_q - 16'd1;
      end
      if (push) begin
         wptr_d      = wptr_q + ptr_t'(1);
         last_code_d = cand[9:1];
         last_pr_d   = cand[0];
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
      end
      // A push into an empty slot at the new head bypasses the array
      if (push && (rptr_d == wptr_q)) head = cand;
      else head = mem_q[rptr_d[AW-1:0]];
      valid_d = (wptr_d != rptr_d) && (pace_d == 16'd0);
      if (valid_d) begin
         code_d = head[9:1];
         pr_d   = head[0];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= cand;
   end

   always_ff @(posedge clk_sys) begin
      tgl_q <= ps2_key[10];
      if (reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         last_code_q <= '0;
         last_pr_q   <= 1'b0;
         pace_q      <= '0;
         valid_q     <= 1'b0;
         code_q      <= '0;
         pr_q        <= 1'b0;
         strobe_q    <= 1'b0;
         ovf_q       <= 1'b0;
         drops_q     <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         last_code_q <= last_code_d;
         last_pr_q   <= last_pr_d;
         pace_q      <= pace_d;
         valid_q     <= valid_d;
         code_q      <= code_d;
         pr_q        <= pr_d;
         strobe_q    <= strobe_d;
         ovf_q       <= ovf_d;
         drops_q     <= drops_d;
      end
   end

   assign evt_valid   = valid_q;
   assign evt_code    = code_q;
   assign evt_pressed = pr_q;
   assign key_strobe  = strobe_q;
   assign fifo_level  = wptr_q - rptr_q;
   assign overflow    = ovf_q;
   assign drop_count  = drops_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: directed events, monitor-side
// checking of popped entries and pop spacing.
module tb_key_event_queue;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] ps2_key = 11'h400;
   logic        evt_ready = 1'b0;
   logic        evt_valid;
   logic [8:0]  evt_code;
   logic        evt_pressed;
   logic        key_strobe;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic [7:0]  drop_count;

   key_event_queue #(
      .DEPTH(8),
      .FILTER_REPEAT(1'b1),
      .PACE_CYCLES(4)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .ps2_key(ps2_key),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_code(evt_code),
      .evt_pressed(evt_pressed),
      .key_strobe(key_strobe),
      .fifo_level(fifo_level),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   always #5 clk_sys = ~clk_sys;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_pop = -1;
   int toggles = 0;
   bit pace_chk = 1'b0;
   logic prev_strobe = 1'b0;
   logic [9:0] sb[$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Monitor: every accepted head is compared against the scoreboard
   always @(negedge clk_sys) begin
      logic [9:0] exp;
      if (key_strobe != prev_strobe) toggles++;
      prev_strobe = key_strobe;
      if (!reset && evt_valid && evt_ready) begin
         chk("pop_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("pop_head", int'({evt_code, evt_pressed}), int'(exp));
         end
         if (pace_chk && last_pop >= 0) chk("pop_gap", cyc - last_pop, 5);
         last_pop = cyc;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [8:0] code, input logic pr,
                       input bit store);
      ps2_key = {~ps2_key[10], pr, code};
      if (store) sb.push_back({code, pr});
      @(posedge clk_sys);
      #1;
   endtask

   task automatic drain();
      pace_chk = 1'b1;
      last_pop = -1;
      evt_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk_sys);
      #1;
      evt_ready = 1'b0;
      pace_chk = 1'b0;
      chk("drain_done", sb.size(), 0);
      @(negedge clk_sys);
      chk("drain_level", int'(fifo_level), 0);
      idle(1);
   endtask

   initial begin
      int t0;
      idle(3);
      reset = 1'b0;
      @(negedge clk_sys);
      chk("rst_code", int'(evt_code), 0);
      chk("rst_pressed", int'(evt_pressed), 0);
      chk("rst_strobe", int'(key_strobe), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_drops", int'(drop_count), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         chk("no_spurious_valid", int'(evt_valid), 0);
      end
      idle(1);

      // single event, one-cycle latency, pop toggles strobe
      evt_ready = 1'b1;
      send(9'h01C, 1'b1, 1'b1);
      @(negedge clk_sys);
      chk("lat_valid", int'(evt_valid), 1);
      chk("lat_code", int'(evt_code), 'h01C);
      chk("lat_pressed", int'(evt_pressed), 1);
      @(negedge clk_sys);
      chk("pop_strobe", int'(key_strobe), 1);
      chk("pop_level", int'(fifo_level), 0);
      idle(1);
      evt_ready = 1'b0;

      // overflow: 10 distinct presses into 8 entries
      idle(6);
      for (int i = 0; i < 10; i++) send(9'(9'h020 + i), 1'b1, i < 8);
      @(negedge clk_sys);
      chk("ovf_level", int'(fifo_level), 8);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_drops", int'(drop_count), 2);
      idle(1);
      drain();

      // repeat filter
      idle(6);
      send(9'h01C, 1'b1, 1'b1);
      send(9'h01C, 1'b1, 1'b0);
      send(9'h01C, 1'b1, 1'b0);
      send(9'h01C, 1'b0, 1'b1);
      send(9'h01C, 1'b1, 1'b1);
      @(negedge clk_sys);
      chk("filt_level", int'(fifo_level), 3);
      chk("filt_drops", int'(drop_count), 2);
      idle(1);
      drain();

      // paced drain of 3 events
      idle(6);
      t0 = toggles;
      send(9'h030, 1'b1, 1'b1);
      send(9'h131, 1'b1, 1'b1);
      send(9'h032, 1'b0, 1'b1);
      drain();
      idle(2);
      chk("pace_toggles", toggles - t0, 3);

      // full FIFO, simultaneous push and pop
      idle(6);
      for (int i = 0; i < 8; i++) send(9'(9'h040 + i), 1'b1, 1'b1);
      @(negedge clk_sys);
      chk("full_level", int'(fifo_level), 8);
      idle(1);
      evt_ready = 1'b1;
      send(9'h048, 1'b1, 1'b1);
      evt_ready = 1'b0;
      @(negedge clk_sys);
      chk("simul_level", int'(fifo_level), 8);
      chk("simul_drops", int'(drop_count), 2);
      idle(1);

      // reset mid-stream
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      sb.delete();
      @(negedge clk_sys);
      chk("mid_rst_level", int'(fifo_level), 0);
      chk("mid_rst_valid", int'(evt_valid), 0);
      chk("mid_rst_overflow", int'(overflow), 0);
      chk("mid_rst_drops", int'(drop_count), 0);
      idle(1);
      send(9'h15A, 1'b0, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
